// File: rtl/ram_test_pkg.sv
// Shared state/mode encodings and the data-pattern generator for the BRAM pattern tester.
package ram_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_INCR = 2'd0,
        MODE_INV  = 2'd1,
        MODE_CHK  = 2'd2,
        MODE_XOR  = 2'd3
    } mode_e;

    localparam int PAT_W = 32;

    // Evaluated at 32 bits; callers truncate to their word width, which keeps sums mod 2**DATA_W.
    function automatic logic [PAT_W-1:0] ram_pattern(
        input mode_e            mode,
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] idx
    );
        logic [PAT_W-1:0] sum;
        sum = seed + idx;
        case (mode)
            MODE_INCR: ram_pattern = sum;
            MODE_INV:  ram_pattern = ~sum;
            MODE_CHK:  ram_pattern = idx[0] ? ~seed : seed;
            default:   ram_pattern = seed ^ idx;
        endcase
    endfunction

endpackage

// File: rtl/ram_test_expect_pipe.sv
// Delays the expected word, its address and a valid flag by LAT clocks so they
// line up with the RAM port-B read data.
module ram_test_expect_pipe #(
    parameter int LAT    = 1,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LAT-1:0]    vld_q;
    logic [DATA_W-1:0] data_q [LAT];
    logic [ADDR_W-1:0] addr_q [LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                data_q[s] <= '0;
                addr_q[s] <= '0;
            end
        end else begin
            vld_q[0]  <= in_vld;
            data_q[0] <= in_data;
            addr_q[0] <= in_addr;
            for (int s = 1; s < LAT; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
                addr_q[s] <= addr_q[s-1];
            end
        end
    end

    assign out_vld  = vld_q[LAT-1];
    assign out_data = data_q[LAT-1];
    assign out_addr = addr_q[LAT-1];

endmodule

// File: rtl/ram_pattern_tester.sv
// Write-then-read self-test engine for a dual-port BRAM: fills every word with a
// pattern on port A, reads it back on port B and reports mismatches.
//
//   state | meaning
//   IDLE  | waiting for start_i or the periodic tick
//   WRITE | one port-A write per clock, index 0..DEPTH-1
//   READ  | one port-B read per clock, index 0..DEPTH-1
//   DRAIN | RD_LATENCY clocks for the last read data to come back
//   DONE  | one clock: done pulse, pass flag updated
module ram_pattern_tester
    import ram_test_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int DEPTH      = 2048,
    parameter int RD_LATENCY = 1,
    parameter int AUTO_EN    = 1,
    parameter int CLK_FREQ   = 50000000,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [DATA_W-1:0]    seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [ADDR_W-1:0]    first_err_addr_o,
    output logic                 first_err_vld_o,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [DATA_W-1:0]    wr_data_o,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [DATA_W-1:0]    rd_data_i
);

    localparam int                TICK_W     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_FREQ - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_e              state_q, state_nx;
    logic [ADDR_W-1:0]   idx_q, idx_nx;
    logic [1:0]          drain_q, drain_nx;
    mode_e               mode_q, mode_nx;
    logic [DATA_W-1:0]   seed_q, seed_nx;
    logic [DATA_W-1:0]   pat_nx;
    logic [DATA_W-1:0]   exp_q;
    logic [TICK_W-1:0]   tick_q;
    logic                tick;
    logic                trigger;

    logic                chk_vld;
    logic [DATA_W-1:0]   chk_exp;
    logic [ADDR_W-1:0]   chk_addr;
    logic                mismatch;

    // Tick counter runs in every state; a tick landing outside IDLE is simply lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tick_q <= '0;
        else if (tick_q == TICK_LAST)
            tick_q <= '0;
        else
            tick_q <= tick_q + TICK_W'(1);
    end

    assign tick    = (AUTO_EN != 0) && (tick_q == TICK_LAST);
    assign trigger = (state_q == IDLE) && (start_i || tick);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            mode_q  <= MODE_INCR;
            seed_q  <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            drain_q <= drain_nx;
            mode_q  <= mode_nx;
            seed_q  <= seed_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        drain_nx = drain_q;
        mode_nx  = mode_q;
        seed_nx  = seed_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_nx = WRITE;
                    idx_nx   = '0;
                    mode_nx  = mode_e'(mode_i);
                    seed_nx  = seed_i;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_nx = READ;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx_q + ADDR_W'(1);
                end
            end
            READ: begin
                if (idx_q == LAST_IDX) begin
                    state_nx = DRAIN;
                    idx_nx   = '0;
                    drain_nx = DRAIN_LAST;
                end else begin
                    idx_nx = idx_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0)
                    state_nx = DONE;
                else
                    drain_nx = drain_q - 2'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so the first write beat
    // appears in the cycle right after the trigger.
    assign pat_nx = DATA_W'(ram_pattern(mode_nx, PAT_W'(seed_nx), PAT_W'(idx_nx)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            exp_q     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            wr_en_o   <= (state_nx == WRITE);
            wr_addr_o <= (state_nx == WRITE) ? idx_nx : '0;
            wr_data_o <= (state_nx == WRITE) ? pat_nx : '0;
            rd_en_o   <= (state_nx == READ);
            rd_addr_o <= (state_nx == READ) ? idx_nx : '0;
            exp_q     <= (state_nx == READ) ? pat_nx : '0;
            busy_o    <= (state_nx != IDLE);
            done_o    <= (state_nx == DONE);
        end
    end

    ram_test_expect_pipe #(
        .LAT    (RD_LATENCY),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_expect_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (rd_en_o),
        .in_data  (exp_q),
        .in_addr  (rd_addr_o),
        .out_vld  (chk_vld),
        .out_data (chk_exp),
        .out_addr (chk_addr)
    );

    assign mismatch = chk_vld && (rd_data_i != chk_exp);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_o        <= '0;
            first_err_vld_o  <= 1'b0;
            first_err_addr_o <= '0;
        end else if (trigger) begin
            err_cnt_o        <= '0;
            first_err_vld_o  <= 1'b0;
            first_err_addr_o <= '0;
        end else if (mismatch) begin
            if (err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            if (!first_err_vld_o) begin
                first_err_vld_o  <= 1'b1;
                first_err_addr_o <= chk_addr;
            end
        end
    end

    // The final compare lands on the clock that enters DONE, so the count is settled here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pass_o <= 1'b0;
        else if (state_q == DONE)
            pass_o <= (err_cnt_o == '0);
    end

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Self-checking bench: three tester instances (latency 1, latency 3 with a 3-bit
// error counter, auto-trigger) each driving a small behavioural dual-port RAM.
module tb_ram_pattern_tester;

    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, rstn_a;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cyc_rel;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: latency 1 ----------------
    logic        a_start, a_busy, a_done, a_pass, a_fev;
    logic [1:0]  a_mode;
    logic [15:0] a_seed, a_err, a_wr_data, a_rd_data;
    logic [10:0] a_fea, a_wr_addr, a_rd_addr;
    logic        a_wr_en, a_rd_en, a_flip5;
    logic [15:0] a_mem [16];

    ram_pattern_tester #(.DATA_W(16), .ADDR_W(11), .DEPTH(D), .RD_LATENCY(1),
                         .AUTO_EN(0), .CLK_FREQ(1000), .ERR_CNT_W(16)) u_a (
        .clk(clk), .rstn(rstn_a), .start_i(a_start), .mode_i(a_mode), .seed_i(a_seed),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err),
        .first_err_addr_o(a_fea), .first_err_vld_o(a_fev),
        .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
        .rd_en_o(a_rd_en), .rd_addr_o(a_rd_addr), .rd_data_i(a_rd_data));

    always @(posedge clk) begin
        if (a_wr_en) a_mem[a_wr_addr[3:0]] <= a_wr_data;
        a_rd_data <= a_rd_en ? (a_mem[a_rd_addr[3:0]] ^ {15'd0, a_flip5 && (a_rd_addr == 11'd5)}) : 16'h0;
    end

    // ---------------- instance B: latency 3, 3-bit error counter ----------------
    logic        b_start, b_busy, b_done, b_pass, b_fev, b_force;
    logic [1:0]  b_mode;
    logic [15:0] b_seed, b_wr_data, b_p1, b_p2, b_p3;
    logic [2:0]  b_err;
    logic [10:0] b_fea, b_wr_addr, b_rd_addr;
    logic        b_wr_en, b_rd_en;
    logic [15:0] b_mem [16];

    ram_pattern_tester #(.DATA_W(16), .ADDR_W(11), .DEPTH(D), .RD_LATENCY(3),
                         .AUTO_EN(0), .CLK_FREQ(1000), .ERR_CNT_W(3)) u_b (
        .clk(clk), .rstn(rstn), .start_i(b_start), .mode_i(b_mode), .seed_i(b_seed),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_cnt_o(b_err),
        .first_err_addr_o(b_fea), .first_err_vld_o(b_fev),
        .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
        .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr), .rd_data_i(b_p3));

    always @(posedge clk) begin
        if (b_wr_en) b_mem[b_wr_addr[3:0]] <= b_wr_data;
        b_p1 <= b_rd_en ? (b_force ? 16'hFFFF : b_mem[b_rd_addr[3:0]]) : 16'h0;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end

    // ---------------- instance C: auto-trigger every 100 clocks ----------------
    logic        c_start, c_busy, c_done, c_pass, c_fev;
    logic [1:0]  c_mode;
    logic [15:0] c_seed, c_err, c_wr_data, c_rd_data;
    logic [10:0] c_fea, c_wr_addr, c_rd_addr;
    logic        c_wr_en, c_rd_en;
    logic [15:0] c_mem [16];
    int          c_t [4];
    int          c_n = 0;

    ram_pattern_tester #(.DATA_W(16), .ADDR_W(11), .DEPTH(D), .RD_LATENCY(1),
                         .AUTO_EN(1), .CLK_FREQ(100), .ERR_CNT_W(16)) u_c (
        .clk(clk), .rstn(rstn), .start_i(c_start), .mode_i(c_mode), .seed_i(c_seed),
        .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass), .err_cnt_o(c_err),
        .first_err_addr_o(c_fea), .first_err_vld_o(c_fev),
        .wr_en_o(c_wr_en), .wr_addr_o(c_wr_addr), .wr_data_o(c_wr_data),
        .rd_en_o(c_rd_en), .rd_addr_o(c_rd_addr), .rd_data_i(c_rd_data));

    always @(posedge clk) begin
        if (c_wr_en) c_mem[c_wr_addr[3:0]] <= c_wr_data;
        c_rd_data <= c_rd_en ? c_mem[c_rd_addr[3:0]] : 16'h0;
    end

    always @(negedge clk) begin
        if (c_done && c_n < 4) begin
            c_t[c_n] <= cyc;
            c_n      <= c_n + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tb_pat(input logic [1:0] m, input logic [15:0] s, input int i);
        logic [15:0] a;
        a = 16'(i);
        case (m)
            2'd0:    return s + a;
            2'd1:    return ~(s + a);
            2'd2:    return i[0] ? ~s : s;
            default: return s ^ a;
        endcase
    endfunction

    // Called on a negedge. done_at = beat index (0 = first write beat) where done_o is seen.
    task automatic run_a(input logic [1:0] m, input logic [15:0] s, input int poke,
                         input logic [15:0] d5, output int done_at);
        done_at = -1;
        a_mode  = m;
        a_seed  = s;
        a_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            a_start = (k == poke);
            if (k < D) begin
                check("wr_en", 32'(a_wr_en), 32'd1);
                check("wr_addr", 32'(a_wr_addr), 32'(k));
                check("wr_data", 32'(a_wr_data), 32'(tb_pat(m, s, k)));
                check("rd_en_in_write", 32'(a_rd_en), 32'd0);
            end else if (k < 2*D) begin
                check("rd_en", 32'(a_rd_en), 32'd1);
                check("rd_addr", 32'(a_rd_addr), 32'(k - D));
                check("wr_en_in_read", 32'(a_wr_en), 32'd0);
            end else begin
                check("idle_rd_en", 32'(a_rd_en), 32'd0);
                check("idle_rd_addr", 32'(a_rd_addr), 32'd0);
            end
            if (k == 5) check("wr_data_i5", 32'(a_wr_data), 32'(d5));
            if (a_done) begin
                done_at = k;
                check("busy_at_done", 32'(a_busy), 32'd1);
                break;
            end
        end
        a_start = 1'b0;
    endtask

    task automatic run_b(input logic [1:0] m, input logic [15:0] s, output int done_at);
        done_at = -1;
        b_mode  = m;
        b_seed  = s;
        b_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_done) begin
                done_at = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] seed;
        logic        flip5;
        int          poke;
        logic [15:0] d5;
        logic        pass;
        logic [15:0] err;
        logic        vld;
        logic [10:0] fea;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int done_at;
        int extra;

        //          mode   seed      flip poke d5        pass err  vld fea
        vecs[0] = '{2'd0, 16'h0100, 1'b0, -1, 16'h0105, 1'b1, 16'd0, 1'b0, 11'd0};
        vecs[1] = '{2'd2, 16'h5555, 1'b1, -1, 16'hAAAA, 1'b0, 16'd1, 1'b1, 11'd5};
        vecs[2] = '{2'd1, 16'h1234, 1'b0, 20, 16'hEDC6, 1'b1, 16'd0, 1'b0, 11'd0};
        vecs[3] = '{2'd3, 16'h00F0, 1'b1, -1, 16'h00F5, 1'b0, 16'd1, 1'b1, 11'd5};
        vecs[4] = '{2'd0, 16'hFFFE, 1'b0, -1, 16'h0003, 1'b1, 16'd0, 1'b0, 11'd0};

        rstn = 1'b0; rstn_a = 1'b0;
        a_start = 1'b0; a_mode = 2'd0; a_seed = 16'h0; a_flip5 = 1'b0;
        b_start = 1'b0; b_mode = 2'd0; b_seed = 16'h0; b_force = 1'b0;
        c_start = 1'b0; c_mode = 2'd0; c_seed = 16'h0042;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_pass", 32'(a_pass), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_fev", 32'(a_fev), 32'd0);
        check("rst_wr", {a_wr_en, a_wr_addr, a_wr_data}, 32'd0);
        check("rst_rd", {a_rd_en, a_rd_addr}, 32'd0);
        check("rst_c_busy", 32'(c_busy), 32'd0);

        rstn = 1'b1; rstn_a = 1'b1;
        cyc_rel = cyc;

        for (int v = 0; v < 5; v++) begin
            a_flip5 = vecs[v].flip5;
            run_a(vecs[v].mode, vecs[v].seed, vecs[v].poke, vecs[v].d5, done_at);
            check($sformatf("v%0d_done_cycle", v), 32'(done_at), 32'(2*D + 1));
            @(negedge clk);
            check($sformatf("v%0d_done_fall", v), 32'(a_done), 32'd0);
            check($sformatf("v%0d_busy_fall", v), 32'(a_busy), 32'd0);
            check($sformatf("v%0d_pass", v), 32'(a_pass), 32'(vecs[v].pass));
            check($sformatf("v%0d_err", v), 32'(a_err), 32'(vecs[v].err));
            check($sformatf("v%0d_fev", v), 32'(a_fev), 32'(vecs[v].vld));
            check($sformatf("v%0d_fea", v), 32'(a_fea), 32'(vecs[v].fea));
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (a_done || a_busy) extra++;
            end
            check($sformatf("v%0d_no_rerun", v), 32'(extra), 32'd0);
        end

        // Reset in the middle of WRITE, then a clean run.
        a_flip5 = 1'b0; a_mode = 2'd0; a_seed = 16'h0100; a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(a_busy), 32'd1);
        check("pre_rst_pass", 32'(a_pass), 32'd1);
        rstn_a = 1'b0;
        #2;
        check("async_rst_busy", 32'(a_busy), 32'd0);
        check("async_rst_wr", {a_wr_en, a_wr_addr, a_wr_data}, 32'd0);
        @(negedge clk);
        check("rst_mid_pass", 32'(a_pass), 32'd0);
        check("rst_mid_wr_en", 32'(a_wr_en), 32'd0);
        check("rst_mid_err", {a_err, a_fev, a_fea}, 32'd0);
        rstn_a = 1'b1;
        @(negedge clk);
        run_a(2'd0, 16'h0100, -1, 16'h0105, done_at);
        check("after_rst_done_cycle", 32'(done_at), 32'(2*D + 1));
        @(negedge clk);
        check("after_rst_pass", 32'(a_pass), 32'd1);
        check("after_rst_err", 32'(a_err), 32'd0);

        // Latency-3 instance: clean run, then a stuck-at-ones RAM.
        run_b(2'd3, 16'hA5A5, done_at);
        check("b_lat3_done_cycle", 32'(done_at), 32'(2*D + 3));
        @(negedge clk);
        check("b_lat3_pass", 32'(b_pass), 32'd1);
        check("b_lat3_err", 32'(b_err), 32'd0);
        repeat (3) @(negedge clk);
        b_force = 1'b1;
        run_b(2'd0, 16'h0000, done_at);
        check("b_sat_done_cycle", 32'(done_at), 32'(2*D + 3));
        @(negedge clk);
        check("b_sat_err", 32'(b_err), 32'd7);
        check("b_sat_fea", 32'(b_fea), 32'd0);
        check("b_sat_fev", 32'(b_fev), 32'd1);
        check("b_sat_pass", 32'(b_pass), 32'd0);
        b_force = 1'b0;

        // Auto-trigger instance: three done pulses 100 clocks apart.
        for (int k = 0; k < 600 && c_n < 3; k++) @(negedge clk);
        check("c_done_count", 32'(c_n >= 3), 32'd1);
        if (c_n >= 3) begin
            check("c_first_done", 32'(c_t[0] - cyc_rel), 32'd133);
            check("c_period_1", 32'(c_t[1] - c_t[0]), 32'd100);
            check("c_period_2", 32'(c_t[2] - c_t[1]), 32'd100);
        end
        check("c_pass", 32'(c_pass), 32'd1);
        check("c_err", {c_err, c_fev, c_fea}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
